// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory port between instruction fetch and the data LSU.
// Data wins by default; a streak limit forces a fetch grant and a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        addr_sel,
  output logic        busy
);

  // Handshake: each requester holds req until its one-cycle ack; a req still
  // high in the cycle after ack is a fresh request. mem_ready is only
  // meaningful while mem_req is high (i.e. in BUSY).
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);
  localparam bit         WD_EN      = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  wd_q, wd_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        addr_sel_q, addr_sel_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wd_d        = wd_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_sel_d  = addr_sel_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (d_req && (!if_req || (streak_q < STREAK_MAX))) begin
          // Streak only grows while fetch is actually being held off.
          if (if_req) streak_d = streak_q + 4'd1;
          state_d     = S_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          addr_sel_d  = 1'b1;
          busy_d      = 1'b1;
          wd_d        = 8'd0;
        end else if (if_req) begin
          streak_d    = 4'd0;
          state_d     = S_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 16'h0000;
          addr_sel_d  = 1'b0;
          busy_d      = 1'b1;
          wd_d        = 8'd0;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          if (addr_sel_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          // Abort: complete the access with err and a zeroed read word.
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (addr_sel_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = 16'h0000;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = 16'h0000;
          end
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      streak_q    <= 4'd0;
      wd_q        <= 8'd0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= 16'h0000;
      d_rdata_q   <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      addr_sel_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wd_q        <= wd_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      addr_sel_q  <= addr_sel_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign addr_sel  = addr_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store, arbitration streak and watchdog.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (watchdog enabled)
  logic        if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic        if_ack, d_ack, err, mem_req, mem_we, addr_sel, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  // Second instance with the watchdog disabled
  logic        nt_if_req = 0, nt_d_req = 0, nt_d_we = 0, nt_mem_ready = 0;
  logic [15:0] nt_if_addr = 0, nt_d_addr = 0, nt_d_wdata = 0, nt_mem_rdata = 0;
  logic        nt_if_ack, nt_d_ack, nt_err, nt_mem_req, nt_mem_we, nt_addr_sel, nt_busy;
  logic [15:0] nt_if_rdata, nt_d_rdata, nt_mem_addr, nt_mem_wdata;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .addr_sel(addr_sel), .busy(busy)
  );

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .if_req(nt_if_req), .if_addr(nt_if_addr), .if_ack(nt_if_ack), .if_rdata(nt_if_rdata),
    .d_req(nt_d_req), .d_we(nt_d_we), .d_addr(nt_d_addr), .d_wdata(nt_d_wdata),
    .d_ack(nt_d_ack), .d_rdata(nt_d_rdata), .err(nt_err),
    .mem_req(nt_mem_req), .mem_we(nt_mem_we), .mem_addr(nt_mem_addr), .mem_wdata(nt_mem_wdata),
    .mem_ready(nt_mem_ready), .mem_rdata(nt_mem_rdata), .addr_sel(nt_addr_sel), .busy(nt_busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_sel[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int grants, d_acks, if_acks, both_acks, cnt;
    logic prev_req;

    // ---- power-on reset ----
    repeat (3) @(posedge clk);
    #1;
    check16("por_outputs", {5'd0, if_ack, d_ack, err, mem_req, mem_we, addr_sel, busy, 4'd0},
            16'h0000);
    rst_n = 1'b1;
    tick();

    // ---- reset while BUSY: everything clears at once, no ack later ----
    d_req = 1; d_we = 0; d_addr = 16'h2000; mem_ready = 0;
    tick();
    check1("rst_busy_memreq", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("rst_async_memreq", mem_req, 1'b0);
    check1("rst_async_busy", busy, 1'b0);
    check1("rst_async_sel", addr_sel, 1'b0);
    check16("rst_async_addr", mem_addr, 16'h0000);
    d_req = 0;
    #3 rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin
      tick();
      if (d_ack || busy || mem_req) cnt++;
    end
    check_int("rst_no_ack", cnt, 0);

    // ---- single fetch ----
    if_req = 1; if_addr = 16'h0040; mem_rdata = 16'hBEEF; mem_ready = 0;
    tick();
    check1("fetch_memreq", mem_req, 1'b1);
    check16("fetch_addr", mem_addr, 16'h0040);
    check1("fetch_sel", addr_sel, 1'b0);
    check1("fetch_we", mem_we, 1'b0);
    check1("fetch_busy", busy, 1'b1);
    check1("fetch_noack_yet", if_ack, 1'b0);
    mem_ready = 1;
    tick();
    check1("fetch_ack", if_ack, 1'b1);
    check16("fetch_rdata", if_rdata, 16'hBEEF);
    check1("fetch_memreq_drop", mem_req, 1'b0);
    check1("fetch_err", err, 1'b0);
    if_req = 0; mem_ready = 0;
    tick();
    check1("fetch_ack_pulse", if_ack, 1'b0);
    tick();
    check1("fetch_idle_busy", busy, 1'b0);

    // ---- store with three wait cycles ----
    d_req = 1; d_we = 1; d_addr = 16'h1000; d_wdata = 16'h1234; mem_rdata = 16'h5A5A;
    tick();
    for (int i = 0; i < 4; i++) begin
      check1($sformatf("st_memreq_%0d", i), mem_req, 1'b1);
      check1($sformatf("st_we_%0d", i), mem_we, 1'b1);
      check16($sformatf("st_addr_%0d", i), mem_addr, 16'h1000);
      check16($sformatf("st_wdata_%0d", i), mem_wdata, 16'h1234);
      check1($sformatf("st_sel_%0d", i), addr_sel, 1'b1);
      check1($sformatf("st_noack_%0d", i), d_ack, 1'b0);
      if (i == 3) mem_ready = 1;
      tick();
    end
    check1("st_ack", d_ack, 1'b1);
    check16("st_rdata_captured", d_rdata, 16'h5A5A);
    check16("st_if_rdata_held", if_rdata, 16'hBEEF);
    check1("st_memreq_drop", mem_req, 1'b0);
    d_req = 0; d_we = 0; mem_ready = 0;
    tick();
    check1("st_ack_pulse", d_ack, 1'b0);
    tick();

    // ---- simultaneous requests from IDLE: D first, IF one access later ----
    d_req = 1; d_addr = 16'h3000; if_req = 1; if_addr = 16'h0050;
    mem_ready = 1; mem_rdata = 16'h1111;
    tick();
    check1("sim_first_sel", addr_sel, 1'b1);
    check16("sim_first_addr", mem_addr, 16'h3000);
    tick();
    check1("sim_d_ack", d_ack, 1'b1);
    check1("sim_if_noack", if_ack, 1'b0);
    check16("sim_d_rdata", d_rdata, 16'h1111);
    d_req = 0; mem_rdata = 16'h2222;
    tick();
    check1("sim_resp_if_noack", if_ack, 1'b0);
    tick();
    check1("sim_second_sel", addr_sel, 1'b0);
    check16("sim_second_addr", mem_addr, 16'h0050);
    tick();
    check1("sim_if_ack", if_ack, 1'b1);
    check16("sim_if_rdata", if_rdata, 16'h2222);
    if_req = 0;
    tick();
    tick();

    // ---- contention: both held high, always-ready memory ----
    d_req = 1; if_req = 1; d_addr = 16'h4444; if_addr = 16'h0ABC; mem_ready = 1;
    grants = 0; d_acks = 0; if_acks = 0; both_acks = 0; cnt = 0;
    prev_req = mem_req;
    while (grants < 10 && cnt < 60) begin
      tick();
      cnt++;
      if (d_ack) d_acks++;
      if (if_ack) if_acks++;
      if (d_ack && if_ack) both_acks++;
      if (mem_req && !prev_req) begin
        check1($sformatf("grant_%0d", grants), addr_sel, exp_sel[grants]);
        grants++;
      end
      prev_req = mem_req;
    end
    check_int("cont_grants", grants, 10);
    d_req = 0; if_req = 0;
    cnt = 0;
    while (!if_ack && cnt < 5) begin
      tick();
      cnt++;
      if (d_ack) d_acks++;
    end
    if (if_ack) if_acks++;
    check_int("cont_d_acks", d_acks, 8);
    check_int("cont_if_acks", if_acks, 2);
    check_int("cont_dual_acks", both_acks, 0);
    mem_ready = 0;
    tick();
    tick();

    // ---- watchdog: load never answered ----
    d_req = 1; d_we = 0; d_addr = 16'h5000; mem_rdata = 16'hFFFF; mem_ready = 0;
    tick();
    check1("to_memreq", mem_req, 1'b1);
    cnt = 0;
    while (!d_ack && cnt < 100) begin
      tick();
      cnt++;
    end
    check_int("to_latency", cnt, 64);
    check1("to_err", err, 1'b1);
    check1("to_ack", d_ack, 1'b1);
    check16("to_rdata_zero", d_rdata, 16'h0000);
    check1("to_memreq_drop", mem_req, 1'b0);
    d_req = 0;
    tick();
    check1("to_err_pulse", err, 1'b0);
    check1("to_ack_pulse", d_ack, 1'b0);

    // ---- watchdog disabled: no abort after 300 cycles ----
    nt_d_req = 1; nt_d_addr = 16'h6000; nt_mem_rdata = 16'hC0DE;
    tick();
    cnt = 0;
    repeat (300) begin
      tick();
      if (nt_d_ack || nt_err || !nt_mem_req) cnt++;
    end
    check_int("nt_no_abort", cnt, 0);
    check1("nt_still_busy", nt_busy, 1'b1);
    nt_mem_ready = 1;
    tick();
    check1("nt_late_ack", nt_d_ack, 1'b1);
    check1("nt_late_err", nt_err, 1'b0);
    check16("nt_late_rdata", nt_d_rdata, 16'hC0DE);
    nt_d_req = 0; nt_mem_ready = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
